perf_timer_bank: RTL



---
 rtl/perf_timer_bank_if.sv | 27 ++
 rtl/perf_timer_bank.sv | 116 +++++++++++
 2 files changed

// File: rtl/perf_timer_bank_if.sv
// Avalon-MM slave bundle for the performance timer bank.
// The master side drives commands; the slave side returns registered read data.
interface perf_timer_bank_if #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned S_WIDTH_A = 6
) ();

   logic [S_WIDTH_A-1:0] address;
   logic [WIDTH-1:0]     writedata;
   logic                 read;
   logic                 write;
   logic [WIDTH/8-1:0]   byteenable;
   logic                 waitrequest;
   logic [WIDTH-1:0]     readdata;
   logic                 readdatavalid;

   modport master (
      output address, writedata, read, write, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, writedata, read, write, byteenable,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/perf_timer_bank.sv
// Bank of NUM_CH free-running cycle counters with software/hardware start-stop,
// snapshot and compare, exposed through one Avalon-MM slave.
module perf_timer_bank #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned S_WIDTH_A = 6
) (
   input  logic              clk,
   input  logic              reset,
   perf_timer_bank_if.slave  slave,
   input  logic [NUM_CH-1:0] hw_start,
   input  logic [NUM_CH-1:0] hw_stop,
   output logic              irq
);

   localparam int unsigned NB = WIDTH / 8;

   logic [WIDTH-1:0]  count_q [NUM_CH];
   logic [WIDTH-1:0]  snap_q  [NUM_CH];
   logic [WIDTH-1:0]  cmp_q   [NUM_CH];
   logic [WIDTH-1:0]  count_inc [NUM_CH];
   logic [NUM_CH-1:0] run_q, ovf_q, hit_q;
   logic [NUM_CH-1:0] ctrl_sel, cmp_wr;
   logic [NUM_CH-1:0] do_start, do_stop, do_clear, do_snap;
   logic [WIDTH-1:0]  rd_mux, readdata_q;
   logic              readdatavalid_q;
   int unsigned       ch_idx;
   logic              ch_ok;
   logic [1:0]        reg_sel;

   assign ch_idx  = 32'(slave.address[S_WIDTH_A-1:2]);
   assign ch_ok   = ch_idx < NUM_CH;
   assign reg_sel = slave.address[1:0];

   always_comb begin
      ctrl_sel = '0;
      cmp_wr   = '0;
      do_start = '0;
      do_stop  = '0;
      do_clear = '0;
      do_snap  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ctrl_sel[i]  = slave.write && ch_ok && (ch_idx == i) && (reg_sel == 2'd0) &&
                        slave.byteenable[0];
         cmp_wr[i]    = slave.write && ch_ok && (ch_idx == i) && (reg_sel == 2'd3);
         do_start[i]  = (ctrl_sel[i] && slave.writedata[0]) || hw_start[i];
         do_stop[i]   = (ctrl_sel[i] && slave.writedata[1]) || hw_stop[i];
         do_clear[i]  = ctrl_sel[i] && slave.writedata[2];
         do_snap[i]   = ctrl_sel[i] && slave.writedata[3];
         count_inc[i] = count_q[i] + WIDTH'(1);
      end
   end

   always_comb begin
      rd_mux = '0;
      if (ch_ok) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == i) begin
               case (reg_sel)
                  2'd0:    rd_mux = WIDTH'({hit_q[i], ovf_q[i], run_q[i]});
                  2'd1:    rd_mux = count_q[i];
                  2'd2:    rd_mux = snap_q[i];
                  default: rd_mux = cmp_q[i];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            count_q[i] <= '0;
            snap_q[i]  <= '0;
            cmp_q[i]   <= '1;
         end
         run_q           <= '0;
         ovf_q           <= '0;
         hit_q           <= '0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
      end else begin
         readdatavalid_q <= slave.read;
         if (slave.read) readdata_q <= rd_mux;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            // Snapshot samples the pre-edge count, so it sees the value a CLEAR discards.
            if (do_snap[i]) snap_q[i] <= count_q[i];
            if (do_clear[i]) begin
               count_q[i] <= '0;
               ovf_q[i]   <= 1'b0;
               hit_q[i]   <= 1'b0;
            end else if (run_q[i]) begin
               count_q[i] <= count_inc[i];
               if (&count_q[i]) ovf_q[i] <= 1'b1;
               if (count_inc[i] == cmp_q[i]) hit_q[i] <= 1'b1;
            end
            if (do_stop[i]) begin
               run_q[i] <= 1'b0;
            end else if (do_start[i]) begin
               run_q[i] <= 1'b1;
            end
            if (cmp_wr[i]) begin
               for (int unsigned b = 0; b < NB; b++) begin
                  if (slave.byteenable[b]) cmp_q[i][8*b +: 8] <= slave.writedata[8*b +: 8];
               end
            end
         end
      end
   end

   assign slave.waitrequest   = 1'b0;
   assign slave.readdata      = readdata_q;
   assign slave.readdatavalid = readdatavalid_q;
   assign irq                 = |(ovf_q | hit_q);

endmodule
